// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
// Purpose: FSM state encoding, zero-register constant and stall-count type
// shared by the hazard controller top and its detection sub-module.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        MULDIV = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [1:0] stall_cnt_t;

endpackage

// File: rtl/hazard_detect_comb.sv
// rtl/hazard_detect_comb.sv - combinational stall-length detector for the ID stage
// Purpose: computes how many bubble cycles the ID instruction needs before its
// operands are available (0, 1 or 2).
// Ports:
//   id_rs1/id_rs2, id_uses_rs1/id_uses_rs2, id_is_branch : ID instruction fields
//   ex_reg_write, ex_mem_read, ex_rd                      : EX instruction fields
//   mem_mem_read, mem_rd                                  : MEM instruction fields
//   stall_n                                               : required stall cycles
module hazard_detect_comb
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_is_branch,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd,
    output stall_cnt_t  stall_n
);

    logic ex_match;
    logic mem_match;

    // x0 is hardwired to zero, so a write to it never creates a dependency.
    assign ex_match  = (ex_rd != REG_ZERO) &&
                       ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                        (id_uses_rs2 && (id_rs2 == ex_rd)));
    assign mem_match = (mem_rd != REG_ZERO) &&
                       ((id_uses_rs1 && (id_rs1 == mem_rd)) ||
                        (id_uses_rs2 && (id_rs2 == mem_rd)));

    // Conditions are checked longest-first so the result is the maximum.
    // Non-branch ALU dependencies are covered by the EX forwarding path;
    // branches resolve in ID and cannot use it.
    always_comb begin
        stall_n = 2'd0;
        if (id_is_branch) begin
            if (ex_mem_read && ex_match) begin
                stall_n = 2'd2;
            end else if ((ex_reg_write && ex_match) || (mem_mem_read && mem_match)) begin
                stall_n = 2'd1;
            end
        end else if (ex_mem_read && ex_match) begin
            stall_n = 2'd1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush controller for the 5-stage pipeline
// Purpose: holds PC and IF/ID, inserts ID/EX and EX/MEM bubbles and flushes
// IF/ID for load-use, branch-in-ID dependencies and multicycle mul/div.
// Outputs are combinational so a stall takes effect in the detecting cycle.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   ID_*, EX_*, MEM_* inputs      : decoded fields of the ID/EX/MEM instructions
//   EX_MulDivStart/EX_MulDivDone  : mul/div start and result-valid pulses
//   PC_Write .. EX_MEM_Bubble     : pipeline register controls
//   stall_cycles                  : cycles with PC_Write low (wrapping)
module pipeline_hazard_controller
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs1,
    input  logic [4:0]       ID_Rs2,
    input  logic             ID_UsesRs1,
    input  logic             ID_UsesRs2,
    input  logic             ID_IsBranch,
    input  logic             ID_BranchTaken,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_Rd,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_Rd,
    input  logic             EX_MulDivStart,
    input  logic             EX_MulDivDone,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             ID_EX_Write,
    output logic             EX_MEM_Bubble,
    output logic [CNT_W-1:0] stall_cycles
);

    hz_state_t        state_q, state_d;
    stall_cnt_t       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    stall_cnt_t       need_n;

    hazard_detect_comb u_detect (
        .id_rs1       (ID_Rs1),
        .id_rs2       (ID_Rs2),
        .id_uses_rs1  (ID_UsesRs1),
        .id_uses_rs2  (ID_UsesRs2),
        .id_is_branch (ID_IsBranch),
        .ex_reg_write (EX_RegWrite),
        .ex_mem_read  (EX_MemRead),
        .ex_rd        (EX_Rd),
        .mem_mem_read (MEM_MemRead),
        .mem_rd       (MEM_Rd),
        .stall_n      (need_n)
    );

    always_comb begin
        PC_Write      = 1'b1;
        IF_ID_Write   = 1'b1;
        IF_ID_Flush   = 1'b0;
        ID_EX_Bubble  = 1'b0;
        ID_EX_Write   = 1'b1;
        EX_MEM_Bubble = 1'b0;
        state_d       = state_q;
        cnt_d         = cnt_q;
        // While in reset the pipeline sees plain RUN controls.
        if (!rst) begin
            unique case (state_q)
                RUN: begin
                    if (EX_MulDivStart) begin
                        // Start and Done together is a single-cycle op: no hold.
                        if (!EX_MulDivDone) begin
                            PC_Write      = 1'b0;
                            IF_ID_Write   = 1'b0;
                            ID_EX_Write   = 1'b0;
                            EX_MEM_Bubble = 1'b1;
                            state_d       = MULDIV;
                        end
                    end else if (need_n != 2'd0) begin
                        PC_Write     = 1'b0;
                        IF_ID_Write  = 1'b0;
                        ID_EX_Bubble = 1'b1;
                        cnt_d        = need_n - 2'd1;
                        if (need_n > 2'd1) begin
                            state_d = STALL;
                        end
                    end else if (ID_BranchTaken) begin
                        // Only reachable with no stall, so flush never meets a hold.
                        IF_ID_Flush = 1'b1;
                    end
                end
                STALL: begin
                    PC_Write     = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Bubble = 1'b1;
                    cnt_d        = cnt_q - 2'd1;
                    if (cnt_q <= 2'd1) begin
                        state_d = RUN;
                    end
                end
                MULDIV: begin
                    if (EX_MulDivDone) begin
                        state_d = RUN;
                    end else begin
                        PC_Write      = 1'b0;
                        IF_ID_Write   = 1'b0;
                        ID_EX_Write   = 1'b0;
                        EX_MEM_Bubble = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, ~PC_Write};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            cnt_q          <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - self-checking bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       br;
        logic       tk;
        logic       exw;
        logic       exr;
        logic [4:0] exrd;
        logic       memr;
        logic [4:0] memrd;
        logic       st;
        logic       dn;
    } in_t;

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write, EX_MEM_Bubble}
    typedef logic [5:0] out_t;

    typedef struct {
        in_t  i;
        logic r;
        out_t o;
        int   sc;
    } vec_t;

    localparam out_t RUNV = 6'b110010;
    localparam out_t STLV = 6'b110110 & 6'b000110;
    localparam out_t MDV  = 6'b000001;
    localparam out_t FLV  = 6'b111010;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_Rs1, ID_Rs2, EX_Rd, MEM_Rd;
    logic        ID_UsesRs1, ID_UsesRs2, ID_IsBranch, ID_BranchTaken;
    logic        EX_RegWrite, EX_MemRead, MEM_MemRead, EX_MulDivStart, EX_MulDivDone;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write, EX_MEM_Bubble;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ID_Rs1         (ID_Rs1),
        .ID_Rs2         (ID_Rs2),
        .ID_UsesRs1     (ID_UsesRs1),
        .ID_UsesRs2     (ID_UsesRs2),
        .ID_IsBranch    (ID_IsBranch),
        .ID_BranchTaken (ID_BranchTaken),
        .EX_RegWrite    (EX_RegWrite),
        .EX_MemRead     (EX_MemRead),
        .EX_Rd          (EX_Rd),
        .MEM_MemRead    (MEM_MemRead),
        .MEM_Rd         (MEM_Rd),
        .EX_MulDivStart (EX_MulDivStart),
        .EX_MulDivDone  (EX_MulDivDone),
        .PC_Write       (PC_Write),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Bubble   (ID_EX_Bubble),
        .ID_EX_Write    (ID_EX_Write),
        .EX_MEM_Bubble  (EX_MEM_Bubble),
        .stall_cycles   (stall_cycles)
    );

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic br, input logic tk,
                               input logic exw, input logic exr, input logic [4:0] exrd,
                               input logic memr, input logic [4:0] memrd,
                               input logic st, input logic dn);
        in_t v;
        v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2; v.br = br; v.tk = tk;
        v.exw = exw; v.exr = exr; v.exrd = exrd; v.memr = memr; v.memrd = memrd;
        v.st = st; v.dn = dn;
        return v;
    endfunction

    task automatic drive(input in_t v, input logic r);
        rst = r;
        ID_Rs1 = v.rs1; ID_Rs2 = v.rs2; ID_UsesRs1 = v.u1; ID_UsesRs2 = v.u2;
        ID_IsBranch = v.br; ID_BranchTaken = v.tk;
        EX_RegWrite = v.exw; EX_MemRead = v.exr; EX_Rd = v.exrd;
        MEM_MemRead = v.memr; MEM_Rd = v.memrd;
        EX_MulDivStart = v.st; EX_MulDivDone = v.dn;
    endtask

    task automatic chk_out(input string nm, input out_t exp);
        out_t got;
        got = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, ID_EX_Write, EX_MEM_Bubble};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: controls got %b expected %b (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic chk_sc(input string nm, input logic [31:0] exp);
        checks++;
        if (stall_cycles !== exp) begin
            errors++;
            $display("FAIL %s: stall_cycles got %0d expected %0d (t=%0t)", nm, stall_cycles, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model: stall length as the maximum over the listed rules,
    // plus a count of owed stall cycles and a mul/div-busy flag.
    int          m_left;
    bit          m_md;
    logic [31:0] m_cnt;

    function automatic int need(input in_t v);
        bit ex, mem;
        int n;
        ex  = (v.exrd != 0) && ((v.u1 && v.rs1 == v.exrd) || (v.u2 && v.rs2 == v.exrd));
        mem = (v.memrd != 0) && ((v.u1 && v.rs1 == v.memrd) || (v.u2 && v.rs2 == v.memrd));
        n = 0;
        if (!v.br && v.exr && ex && n < 1)           n = 1;
        if (v.br && v.exr && ex && n < 2)            n = 2;
        if (v.br && v.exw && !v.exr && ex && n < 1)  n = 1;
        if (v.br && v.memr && mem && n < 1)          n = 1;
        return n;
    endfunction

    task automatic model_step(input in_t v, input logic r, output out_t o);
        int n;
        o = RUNV;
        if (r) begin
            m_left = 0; m_md = 0;
        end else if (m_md) begin
            if (v.dn) m_md = 0;
            else      o = MDV;
        end else if (m_left > 0) begin
            o = STLV;
            m_left--;
        end else if (v.st) begin
            if (!v.dn) begin
                o = MDV; m_md = 1;
            end
        end else begin
            n = need(v);
            if (n > 0) begin
                o = STLV; m_left = n - 1;
            end else if (v.tk) begin
                o = FLV;
            end
        end
    endtask

    vec_t tbl[15];
    in_t  idle;

    initial begin
        in_t  v;
        out_t eo;
        bit   synced;

        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle, 1'b1);

        tbl[0]  = '{idle, 1'b1, RUNV, -1};
        tbl[1]  = '{mk(5, 1, 1, 1, 0, 0, 1, 1, 5, 0, 0, 0, 0), 1'b0, STLV, 0};  // load-use
        tbl[2]  = '{idle, 1'b0, RUNV, 1};
        tbl[3]  = '{mk(0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0), 1'b0, RUNV, 1};  // lw x0
        tbl[4]  = '{mk(7, 2, 1, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0), 1'b0, STLV, 1};  // beq after lw
        tbl[5]  = '{mk(7, 2, 1, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0), 1'b0, STLV, 2};  // STALL, taken ignored
        tbl[6]  = '{mk(7, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, FLV,  3};
        tbl[7]  = '{mk(3, 0, 1, 1, 1, 1, 1, 0, 3, 0, 0, 0, 0), 1'b0, STLV, 3};  // bne after add
        tbl[8]  = '{mk(3, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, FLV,  4};
        tbl[9]  = '{idle, 1'b0, RUNV, 4};
        tbl[10] = '{mk(1, 9, 1, 1, 1, 0, 0, 0, 0, 1, 9, 0, 0), 1'b0, STLV, 4};  // branch, lw in MEM
        tbl[11] = '{idle, 1'b0, RUNV, 5};
        tbl[12] = '{mk(5, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0), 1'b0, RUNV, 5};  // rs1 unused
        tbl[13] = '{mk(4, 0, 1, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0), 1'b0, RUNV, 5};  // ALU dep forwarded
        tbl[14] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b0, RUNV, 5};  // single-cycle muldiv

        #1;
        for (int k = 0; k < 15; k++) begin
            drive(tbl[k].i, tbl[k].r);
            #3;
            chk_out($sformatf("table[%0d]", k), tbl[k].o);
            if (tbl[k].sc >= 0) chk_sc($sformatf("table_sc[%0d]", k), tbl[k].sc);
            tick();
        end

        // Multicycle mul/div: start at cycle 10, done at cycle 44.
        drive(idle, 1'b1);
        tick();
        for (int c = 0; c <= 45; c++) begin
            v = idle;
            v.st = (c == 10);
            v.dn = (c == 44);
            drive(v, 1'b0);
            #3;
            if (c >= 10 && c <= 43) chk_out($sformatf("muldiv_hold[%0d]", c), MDV);
            else                    chk_out($sformatf("muldiv_run[%0d]", c), RUNV);
            tick();
        end
        chk_sc("muldiv_stall_cycles", 32'd34);

        // Reset during the STALL cycle of a 2-cycle branch stall.
        v = mk(7, 2, 1, 1, 1, 1, 1, 1, 7, 0, 0, 0, 0);
        drive(v, 1'b0);
        #3;
        chk_out("rst_mid_first", STLV);
        tick();
        drive(v, 1'b1);
        tick();
        drive(idle, 1'b0);
        #3;
        chk_out("rst_mid_after", RUNV);
        chk_sc("rst_mid_sc", 32'd0);
        tick();

        // Randomized run against the reference model.
        synced = 0;
        m_left = 0; m_md = 0; m_cnt = 0;
        for (int k = 0; k < 3000; k++) begin
            v.rs1   = 5'($urandom_range(0, 3));
            v.rs2   = 5'($urandom_range(0, 3));
            v.u1    = 1'($urandom);
            v.u2    = 1'($urandom);
            v.br    = ($urandom % 3) == 0;
            v.tk    = 1'($urandom);
            v.exr   = ($urandom % 3) == 0;
            v.exw   = v.exr | 1'($urandom);
            v.exrd  = 5'($urandom_range(0, 3));
            v.memr  = ($urandom % 3) == 0;
            v.memrd = 5'($urandom_range(0, 3));
            v.st    = ($urandom % 25) == 0;
            v.dn    = m_md ? (($urandom % 8) == 0) : (($urandom % 6) == 0);
            drive(v, (k == 0) || (($urandom % 200) == 0));
            #3;
            model_step(v, rst, eo);
            chk_out($sformatf("rand[%0d]", k), eo);
            if (synced) chk_sc($sformatf("rand_sc[%0d]", k), m_cnt);
            if (rst) begin
                m_cnt = 0; synced = 1;
            end else if (eo[5] == 1'b0) begin
                m_cnt = m_cnt + 1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Stall/flush controller for the 5-stage RISC-V pipeline; sits in ID, alongside the ALU, memory and branch forwarding units.
- Detects hazards that forwarding cannot cover: load-use, branch-in-ID operand dependencies, and the multicycle mul/div unit in EX.
- Drives PC, IF/ID and ID/EX hold, bubble and flush controls.
- Sequences multi-cycle stalls with a small FSM and a stall counter, and keeps a stall-cycle performance counter.

Parameters:
- CNT_W, 32, width of the stall-cycle performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ID_Rs1  in  5  rs1 of instruction in ID
- ID_Rs2  in  5  rs2 of instruction in ID
- ID_UsesRs1  in  1  ID instruction reads rs1
- ID_UsesRs2  in  1  ID instruction reads rs2
- ID_IsBranch  in  1  ID instruction is branch/jalr resolved in ID
- ID_BranchTaken  in  1  branch ALU in ID redirects PC
- EX_RegWrite  in  1  EX instruction writes Rd
- EX_MemRead  in  1  EX instruction is a load
- EX_Rd  in  5  EX destination
- MEM_MemRead  in  1  MEM instruction is a load
- MEM_Rd  in  5  MEM destination
- EX_MulDivStart  in  1  one-cycle pulse, mul/div entered EX
- EX_MulDivDone  in  1  one-cycle pulse, mul/div result valid
- PC_Write  out  1  1 = PC advances
- IF_ID_Write  out  1  1 = IF/ID register loads
- IF_ID_Flush  out  1  1 = IF/ID loads a NOP
- ID_EX_Bubble  out  1  1 = ID/EX loads a NOP
- ID_EX_Write  out  1  1 = ID/EX register loads
- EX_MEM_Bubble  out  1  1 = EX/MEM loads a NOP
- stall_cycles  out  CNT_W  count of cycles with PC_Write=0

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: FSM=RUN, counter=0, stall_cycles=0. Outputs take RUN/no-hazard values: PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, all bubble/flush signals 0.
- Outputs are combinational from state, counter and inputs: zero-latency stall in the detecting cycle.
- Register x0 never creates a hazard.
- A source "matches" Rd when UsesRsN=1 and RsN==Rd!=0.
- Required stall count n, evaluated only in RUN:
  - load in EX matches, non-branch: n=1
  - branch, load in EX matches: n=2
  - branch, non-load RegWrite in EX matches: n=1
  - branch, load in MEM matches (MEM_Rd): n=1
  - else n=0
  - Maximum over all applicable conditions is taken.
- States RUN, STALL, MULDIV.
- RUN:
  - if EX_MulDivStart: go to MULDIV; this cycle acts as a MULDIV cycle.
  - else if n>0: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; counter<=n-1. If n-1>0 go to STALL, else stay in RUN.
  - else if ID_BranchTaken: IF_ID_Flush=1, one cycle.
- STALL: same controls as an n>0 stall (PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1); counter decrements; at counter==1 go to RUN. No re-detection in STALL.
- MULDIV:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Write=0 (hold), EX_MEM_Bubble=1.
  - On EX_MulDivDone: release that same cycle, with all controls at RUN values and EX_MEM_Bubble=0; go to RUN.
- EX_MulDivStart and EX_MulDivDone in the same cycle (single-cycle op): no stall.
- ID_BranchTaken is ignored while any stall is asserted; the branch operands are not yet valid.
- Flush has priority below stall; IF_ID_Flush and IF_ID_Write=0 are never both asserted.
- stall_cycles increments every cycle PC_Write=0 and wraps at 2^CNT_W.
- rst mid-stall: return to RUN next edge, counter cleared, no residual bubble.

Decomposition:
- Shared package `pipeline_ctrl_pkg`:
  - enum hz_state_t {RUN, STALL, MULDIV}
  - constant REG_ZERO=5'd0
  - typedef stall_cnt_t, logic[1:0]
- One natural sub-module: `hazard_detect_comb`, purely combinational, computing n from the ID/EX/MEM fields.
- The FSM, counter and output decode live in the top.

Test Plan:
- Load-use: EX lw x5, ID add x6,x5,x1 -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next cycle all RUN values; stall_cycles=1.
- Branch after load: EX lw x7, ID beq x7,x2 -> 2 consecutive stall cycles (state RUN->STALL->RUN); no flush while stalled even if ID_BranchTaken=1 in those cycles.
- Branch after ALU op: EX add x3 (RegWrite=1), ID bne x3,x0 -> exactly 1 stall. Then ID_BranchTaken=1 -> IF_ID_Flush=1 for exactly one cycle.
- x0 guard: EX lw x0, ID add x1,x0,x0 -> no stall, PC_Write=1.
- MulDiv: EX_MulDivStart at cycle 10, EX_MulDivDone at cycle 44 -> PC_Write=0, ID_EX_Write=0, EX_MEM_Bubble=1 for cycles 10-43; released at cycle 44; stall_cycles=34. Same-cycle Start+Done -> no stall.
- Reset mid-stall: assert rst during the first STALL cycle of a 2-cycle branch stall -> next cycle PC_Write=1, ID_EX_Bubble=0, stall_cycles=0.
